miriscv_data_bus: RTL and testbench
===================================

# miriscv_data_bus

Parametrised data-side interconnect between the `miriscv_core` data port and N memory-mapped slaves (RAM, peripherals). Decodes each request against per-slave address windows and forwards it with a local offset address. Tracks up to `MAX_OUTST` in-order outstanding transactions in a routing FIFO, returns each response from the owning slave, and generates an error response for unmapped addresses. Supersedes the single-window "address < RAM_SIZE" gating in the top level.

## Interface
- `N_SLAVES`, 2, number of slave ports (1..8)
- `SLV_BASE`, {32'h8000_0000, 32'h0000_0000}, packed `N_SLAVES`×32 window bases; slave i is at bits [32i+31:32i]
- `SLV_SIZE`, {32'h100, 32'h100}, packed `N_SLAVES`×32 window sizes in bytes; each is a power of two, and each base is aligned to its size
- `MAX_OUTST`, 2, maximum accepted-but-unanswered transactions (1..8)
- `clk_i`  in  1  clock; all logic on rising edge
- `rst_i`  in  1  reset; synchronous, active-high
- `core_req_i`  in  1  core request valid
- `core_we_i`  in  1  1 = write
- `core_be_i`  in  4  byte enables
- `core_addr_i`  in  32  byte address
- `core_wdata_i`  in  32  write data
- `core_gnt_o`  out  1  request accepted this cycle
- `core_rvalid_o`  out  1  response valid (reads and writes)
- `core_rdata_o`  out  32  read data; 0 unless rvalid with no error
- `core_err_o`  out  1  error response; valid only with rvalid
- `slv_req_o`  out  N_SLAVES  per-slave request
- `slv_we_o` / `slv_be_o` / `slv_wdata_o`  out  1/4/32  broadcast copies of the core fields
- `slv_addr_o`  out  32  `core_addr_i - SLV_BASE[sel]`
- `slv_gnt_i`  in  N_SLAVES  per-slave grant
- `slv_rvalid_i`  in  N_SLAVES  per-slave response valid
- `slv_rdata_i`  in  N_SLAVES×32  packed read data

## Operation
- Decode: `hit[i] = (core_addr_i & ~(SLV_SIZE[i]-1)) == SLV_BASE[i]`. The lowest hit index wins. No hit selects the internal error target `ERR = N_SLAVES`.
- Accept condition: `core_req_i && count < MAX_OUTST`. The accept condition never depends on `slv_rvalid_i`; there is no combinational rvalid→gnt path.
  - Mapped target: `slv_req_o[sel]` = accept condition, and `core_gnt_o = slv_gnt_i[sel]`.
  - ERR target: `core_gnt_o` = 1 immediately, and no slave sees a request.
- On grant, push `sel` into the routing FIFO. All other `slv_req_o` bits are 0.
- Response is driven by the FIFO head when `count > 0`.
  - Head is slave k: `core_rvalid_o = slv_rvalid_i[k]`, `core_rdata_o = slv_rdata_i[k]`, `core_err_o = 0`. Pop when rvalid.
  - Head is ERR: `core_rvalid_o = 1`, `core_err_o = 1`, `core_rdata_o = 0`. Pop the same cycle.
- `slv_rvalid_i` from a non-head slave, or while the FIFO is empty, is ignored and dropped.
- Simultaneous push and pop: both take effect, and count is unchanged.
- Slave contract:
  - rvalid comes at least 1 cycle after gnt.
  - Each slave responds in its own acceptance order.
  - A slave never raises rvalid for an unaccepted request.

## Timing
- Request path is combinational: decode → `slv_req_o` / `core_gnt_o` in the same cycle.
- Response path for mapped slaves is combinational from `slv_rvalid_i` / `slv_rdata_i`. Minimum latency from gnt to rvalid is 1 cycle, set by the slave.
- ERR response arrives exactly 1 cycle after gnt if the FIFO was otherwise empty. Otherwise it arrives the cycle the entry reaches the head.
- Full (`count == MAX_OUTST`): `core_gnt_o = 0` and all `slv_req_o = 0`, even if a pop happens this cycle.
- FIFO pointers wrap modulo `MAX_OUTST`. Count is held in `$clog2(MAX_OUTST+1)` bits.
- Reset values: count 0, pointers 0, FIFO empty. With `rst_i` = 1, all outputs are 0: `core_gnt_o`, `core_rvalid_o`, `core_err_o`, `core_rdata_o`, `slv_req_o`.
- Reset mid-operation: pending entries are discarded. Slave rvalids arriving after reset are ignored because the FIFO is empty.

## Structure
- Package `miriscv_bus_pkg`:
  - `ADDR_W = 32`, `DATA_W = 32`, `BE_W = 4`
  - `typedef logic [BE_W-1:0] be_t`
  - function `decode_window(addr, base, size)`
- Sub-module `miriscv_route_fifo`:
  - Synchronous FIFO, parameters `DEPTH = MAX_OUTST` and `W = $clog2(N_SLAVES+1)`.
  - Ports: push/pop/full/empty/count/head. Synchronous active-high `rst_i`.

## Test plan
- Read from RAM at 0x10, slave 0 grants at once and returns rvalid 1 cycle later with 0xDEADBEEF → `slv_addr_o` = 0x10, core sees gnt then rvalid with rdata 0xDEADBEEF, err 0.
- Write to 0x8000_0004 → `slv_req_o` = 2'b10, `slv_addr_o` = 0x4, and slave 1 rvalid produces core rvalid with err 0.
- Read 0x0000_0400 (unmapped) → gnt in the same cycle with no `slv_req_o`; next cycle rvalid=1, err=1, rdata=0.
- Back-to-back reads to slave 0 then slave 1, MAX_OUTST=2, slaves delaying 3 cycles → third request stalls with gnt=0; responses return in order; an early slave-1 rvalid while the head is slave 0 is dropped.
- Mapped read pending, then an unmapped request → ERR response only after the slave-0 response pops.
- `rst_i` asserted with 2 outstanding, slaves respond 1 cycle after reset → no core rvalid; count 0; the next read completes normally.

Source files
------------

// File: rtl/miriscv_bus_pkg.sv
// Shared widths and address-window helper
// for the miriscv data-side interconnect.
package miriscv_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef logic [BE_W-1:0] be_t;

  // Size is a power of two and base is size-aligned.
  function automatic logic decode_window(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] size
  );
    return (addr & ~(size - ADDR_W'(1))) == base;
  endfunction

endpackage

// File: rtl/miriscv_route_fifo.sv
// In-order routing FIFO: remembers which target
// owns each outstanding transaction.
module miriscv_route_fifo
  import miriscv_bus_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [W-1:0]               head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push_i) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= nxt(r_wptr);
      end
      if (pop_i) begin
        r_rptr <= nxt(r_rptr);
      end
      unique case ({push_i, pop_i})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rptr];

endmodule

// File: rtl/miriscv_data_bus.sv
// Data-side interconnect: window decode, in-order
// response routing, error target for unmapped space.
module miriscv_data_bus
  import miriscv_bus_pkg::*;
#(
  parameter int N_SLAVES = 2,
  parameter logic [N_SLAVES*32-1:0] SLV_BASE =
    {32'h8000_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0] SLV_SIZE =
    {32'h0000_0100, 32'h0000_0100},
  parameter int MAX_OUTST = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       core_req_i,
  input  logic                       core_we_i,
  input  be_t                        core_be_i,
  input  logic [ADDR_W-1:0]          core_addr_i,
  input  logic [DATA_W-1:0]          core_wdata_i,
  output logic                       core_gnt_o,
  output logic                       core_rvalid_o,
  output logic [DATA_W-1:0]          core_rdata_o,
  output logic                       core_err_o,
  output logic [N_SLAVES-1:0]        slv_req_o,
  output logic                       slv_we_o,
  output be_t                        slv_be_o,
  output logic [DATA_W-1:0]          slv_wdata_o,
  output logic [ADDR_W-1:0]          slv_addr_o,
  input  logic [N_SLAVES-1:0]        slv_gnt_i,
  input  logic [N_SLAVES-1:0]        slv_rvalid_i,
  input  logic [N_SLAVES*DATA_W-1:0] slv_rdata_i
);

  localparam int SW = $clog2(N_SLAVES+1);
  localparam int CW = $clog2(MAX_OUTST+1);
  localparam logic [SW-1:0] ERR = SW'(N_SLAVES);

  logic [SW-1:0]     w_sel;
  logic [ADDR_W-1:0] w_base;
  logic              w_sel_gnt;
  logic              w_accept;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [SW-1:0]     w_head;
  logic              w_head_ok;

  // Scan downward so the lowest hit index wins.
  always_comb begin
    w_sel  = ERR;
    w_base = '0;
    for (int i = N_SLAVES-1; i >= 0; i--) begin
      if (decode_window(core_addr_i,
                        SLV_BASE[32*i +: 32],
                        SLV_SIZE[32*i +: 32])) begin
        w_sel  = SW'(i);
        w_base = SLV_BASE[32*i +: 32];
      end
    end
  end

  assign w_accept = !rst_i && core_req_i && !w_full;

  always_comb begin
    w_sel_gnt = 1'b1;
    slv_req_o = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (w_sel == SW'(i)) begin
        w_sel_gnt    = slv_gnt_i[i];
        slv_req_o[i] = w_accept;
      end
    end
  end

  assign core_gnt_o  = w_accept && w_sel_gnt;
  assign slv_we_o    = core_we_i;
  assign slv_be_o    = core_be_i;
  assign slv_wdata_o = core_wdata_i;
  assign slv_addr_o  = core_addr_i - w_base;

  assign w_head_ok = !rst_i && !w_empty;

  always_comb begin
    core_rvalid_o = 1'b0;
    core_err_o    = 1'b0;
    core_rdata_o  = '0;
    if (w_head_ok) begin
      if (w_head == ERR) begin
        core_rvalid_o = 1'b1;
        core_err_o    = 1'b1;
      end else begin
        for (int i = 0; i < N_SLAVES; i++) begin
          if (w_head == SW'(i)) begin
            core_rvalid_o = slv_rvalid_i[i];
            if (slv_rvalid_i[i]) begin
              core_rdata_o = slv_rdata_i[32*i +: 32];
            end
          end
        end
      end
    end
  end

  miriscv_route_fifo #(
    .DEPTH (MAX_OUTST),
    .W     (SW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (core_gnt_o),
    .data_i  (w_sel),
    .pop_i   (core_rvalid_o),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count),
    .head_o  (w_head)
  );

  a_count_bound: assert property (
    @(posedge clk_i) disable iff (rst_i)
    w_count <= CW'(MAX_OUTST)
  );

endmodule

// File: tb/tb_miriscv_data_bus.sv
// Random and directed checks of miriscv_data_bus
// against a transaction-queue reference model.
module tb_miriscv_data_bus;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  sreq;
  logic        swe;
  logic [3:0]  sbe;
  logic [31:0] swdata;
  logic [31:0] saddr;
  logic [1:0]  sgnt;
  logic [1:0]  srv;
  logic [63:0] srdata;

  always #5 clk = ~clk;

  miriscv_data_bus dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .core_req_i    (req),
    .core_we_i     (we),
    .core_be_i     (be),
    .core_addr_i   (addr),
    .core_wdata_i  (wdata),
    .core_gnt_o    (gnt),
    .core_rvalid_o (rvalid),
    .core_rdata_o  (rdata),
    .core_err_o    (err),
    .slv_req_o     (sreq),
    .slv_we_o      (swe),
    .slv_be_o      (sbe),
    .slv_wdata_o   (swdata),
    .slv_addr_o    (saddr),
    .slv_gnt_i     (sgnt),
    .slv_rvalid_i  (srv),
    .slv_rdata_i   (srdata)
  );

  typedef struct {
    int          tgt;
    logic [31:0] data;
    int          ready;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // 0 = RAM, 1 = peripheral window, 2 = unmapped
  function automatic int tgt_of(input logic [31:0] a);
    if (a < 32'h100) return 0;
    if (a >= 32'h8000_0000 && a < 32'h8000_0100)
      return 1;
    return 2;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 4))
      0, 1: return {24'h0, r[7:0]};
      2, 3: return {24'h80_0000, r[7:0]};
      default: begin
        case ($urandom_range(0, 2))
          0:       return 32'h0000_0400;
          1:       return 32'h8000_0100 | {24'h0, r[7:0]};
          default: return r | 32'h1000_0000;
        endcase
      end
    endcase
  endfunction

  task automatic cycle(input bit          r,
                       input bit          rq,
                       input bit          w,
                       input logic [31:0] a,
                       input logic [1:0]  sg,
                       input bit          rv_ok,
                       input logic [1:0]  spur,
                       input logic [31:0] d,
                       input int          dly);
    int          t;
    int          hk;
    bit          e_acc;
    bit          e_gnt;
    bit          e_rv;
    bit          e_err;
    logic [31:0] e_rd;
    logic [1:0]  e_req;
    @(negedge clk);
    rst    = r;
    req    = rq;
    we     = w;
    addr   = a;
    be     = 4'($urandom);
    wdata  = $urandom;
    sgnt   = sg;
    srv    = '0;
    srdata = {$urandom, $urandom};
    t  = tgt_of(a);
    hk = (q.size() > 0) ? q[0].tgt : -1;
    for (int j = 0; j < 2; j++)
      if (spur[j] && hk != j) srv[j] = 1'b1;
    if (hk >= 0 && hk < 2 && rv_ok &&
        q[0].ready <= cyc) begin
      srv[hk] = 1'b1;
      srdata[hk*32 +: 32] = q[0].data;
    end
    e_acc = !r && rq && (q.size() < MAXO);
    e_req = (e_acc && t < 2) ? 2'(1 << t) : 2'b00;
    e_gnt = e_acc && ((t == 2) ? 1'b1 : sg[t]);
    e_rv  = 1'b0;
    e_err = 1'b0;
    e_rd  = '0;
    if (!r && hk == 2) begin
      e_rv  = 1'b1;
      e_err = 1'b1;
    end else if (!r && hk >= 0) begin
      e_rv = srv[hk];
      if (e_rv) e_rd = q[0].data;
    end
    #1;
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("slv_req", 32'(sreq), 32'(e_req));
    check("rvalid", 32'(rvalid), 32'(e_rv));
    check("err", 32'(err), 32'(e_err));
    check("rdata", rdata, e_rd);
    if (e_req != 2'b00) begin
      check("slv_addr", saddr,
            a - ((t == 1) ? 32'h8000_0000 : 32'h0));
      check("slv_wdata", swdata, wdata);
      check("slv_we", 32'(swe), 32'(w));
      check("slv_be", 32'(sbe), 32'(be));
    end
    @(posedge clk);
    if (r) begin
      q.delete();
    end else begin
      if (e_rv) void'(q.pop_front());
      if (e_gnt) q.push_back('{t, d, cyc + 1 + dly});
    end
    cyc++;
  endtask

  task automatic idle(input bit rv_ok,
                      input logic [1:0] spur);
    cycle(0, 0, 0, 32'h0, 2'b00, rv_ok, spur, 32'h0, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() > 0; k++)
      idle(1, 2'b00);
    check("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; be = '0;
    addr = '0; wdata = '0; sgnt = '0;
    srv = '0; srdata = '0;

    cycle(1, 1, 0, 32'h10, 2'b11, 1, 2'b11, 32'h0, 0);
    cycle(1, 0, 0, 32'h0, 2'b00, 1, 2'b00, 32'h0, 0);

    cycle(0, 1, 0, 32'h10, 2'b01, 0, 2'b00,
          32'hDEAD_BEEF, 0);
    idle(1, 2'b00);
    drain();

    cycle(0, 1, 1, 32'h8000_0004, 2'b10, 0, 2'b00,
          32'h1234_5678, 0);
    idle(1, 2'b00);
    drain();

    cycle(0, 1, 0, 32'h0000_0400, 2'b00, 0, 2'b00,
          32'h0, 0);
    idle(0, 2'b00);
    drain();

    cycle(0, 1, 0, 32'h20, 2'b01, 0, 2'b00,
          32'hAAAA_0001, 3);
    cycle(0, 1, 0, 32'h8000_0020, 2'b10, 0, 2'b00,
          32'hBBBB_0002, 3);
    cycle(0, 1, 0, 32'h30, 2'b11, 0, 2'b00,
          32'hCCCC_0003, 0);
    idle(1, 2'b10);
    idle(1, 2'b10);
    drain();

    cycle(0, 1, 0, 32'h40, 2'b01, 0, 2'b00,
          32'h5555_AAAA, 2);
    cycle(0, 1, 0, 32'h0000_0400, 2'b00, 0, 2'b00,
          32'h0, 0);
    drain();

    cycle(0, 1, 0, 32'h44, 2'b01, 0, 2'b00,
          32'h0101_0101, 3);
    cycle(0, 1, 0, 32'h8000_0044, 2'b10, 0, 2'b00,
          32'h0202_0202, 3);
    cycle(1, 0, 0, 32'h0, 2'b00, 0, 2'b00, 32'h0, 0);
    idle(1, 2'b11);
    idle(1, 2'b11);
    cycle(0, 1, 0, 32'h48, 2'b01, 0, 2'b00,
          32'h0303_0303, 0);
    idle(1, 2'b00);
    drain();

    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 3) != 0,
            1'($urandom),
            rand_addr(),
            2'($urandom),
            $urandom_range(0, 2) != 0,
            ($urandom_range(0, 7) == 0) ?
              2'($urandom) : 2'b00,
            $urandom,
            $urandom_range(0, 3));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
